esm_issue_scheduler: RTL and testbench
======================================

// Module: esm_issue_scheduler
// PURPOSE
//  Issue controller for the ESM instruction buffer. Fills a BS-entry buffer from the incoming stream,
//  then drains it out of order: each cycle issues the oldest slot free of register hazards against a
//  fixed-latency writeback scoreboard. Sits between instruction fetch and the ESM execution datapath.
// PARAMETERS
//  IW      32  instruction word width (RV32 field layout: rd[11:7], rs1[19:15], rs2[24:20])
//  BS      16  buffer slots, power of two, >=2
//  REGNUM  32  architectural registers; x0 is never tracked
//  LAT     3   cycles from issue until rd is written back (1..8)
// PORTS
//  clk            in   1           clock
//  rst            in   1           asynchronous active-high reset
//  in_valid       in   1           instruction offered
//  in_instr       in   IW          instruction word; all-zero word is the end-of-stream terminator
//  in_regwrite    in   1           instruction writes rd
//  in_alusrc      in   1           1 = immediate operand, rs2 not read
//  in_ready       out  1           scheduler accepts in_instr this cycle
//  issue_valid    out  1           issue_instr/issue_slot valid
//  issue_instr    out  IW          instruction being issued
//  issue_slot     out  clog2(BS)   buffer slot it came from
//  issue_ready    in   1           downstream accepts issue
//  occupancy      out  clog2(BS)+1 valid slots held
//  busy           out  1           state != IDLE or scoreboard non-empty
// BEHAVIOUR
//  Reset: state IDLE, all slot valids 0, scoreboard 0, LAT pipeline cleared; in_ready=1 (IDLE accepts),
//   issue_valid=0, issue_instr=0, issue_slot=0, occupancy=0, busy=0. Reset mid-operation discards all.
//  States: IDLE -> FILL on first accepted non-zero word. FILL -> DRAIN when occupancy reaches BS or a
//   terminator is accepted. DRAIN -> IDLE when occupancy==0 and issue_valid==0 (scoreboard may still
//   drain in IDLE; busy stays 1 until it empties). Terminator in IDLE: consumed, no state change.
//  Fill: in_ready=1 in IDLE/FILL while occupancy<BS, 0 in DRAIN. Accepted word written to slot
//   occupancy (slots filled 0..n-1, so lower index = older); terminator never stored. Handshake
//   in_valid&in_ready, one word per cycle.
//  Slot ready (DRAIN): valid, and for srcs S={rs1} plus rs2 if !alusrc, dest D=rd if regwrite & rd!=0:
//   no S register pending in scoreboard; no older valid slot writes any S (RAW); no older valid slot
//   writes D (WAW) or reads D (WAR). x0 never creates a hazard.
//  Issue: when issue_valid==0, lowest-index ready slot is registered onto issue_* next cycle (1-cycle
//   select latency). Once issue_valid=1, outputs hold stable until issue_valid&issue_ready; on that
//   edge slot valid clears, occupancy decrements, D marked pending, D pushed into LAT-deep pipeline.
//   Same edge may load the next selection (back-to-back issue, selection excludes the handshaking slot).
//  Scoreboard: one pending bit per register; set on issue, cleared when tag exits the LAT pipeline.
//   Simultaneous set and clear of same register: set wins. Selection sees pending before update.
//  No ready slot and issue_valid==0: stall, issue_valid stays 0 (hazards resolve as LAT expires).
//  Arithmetic: occupancy saturates by construction (0..BS); slot index never wraps (buffer refills
//   from 0 after DRAIN completes).
// CONFIGURATION
//  ESM_SCHED_STATS_EN defined: adds outputs stat_issued[31:0] (count of issue handshakes) and
//   stat_stalls[31:0] (DRAIN cycles with occupancy>0 and issue_valid==0); both wrap at 2^32, reset 0.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  T1 fill-to-full: 16 independent ADDIs (rd=1..16,rs1=0) -> in_ready drops after 16th, 16 issues in
//     slot order 0..15 back-to-back with issue_ready=1, busy falls LAT cycles after last issue.
//  T2 terminator: 3 words then 0x00000000 -> DRAIN entered with occupancy=3, terminator not issued.
//  T3 RAW: slot0 add x5,x1,x2; slot1 add x6,x5,x3; slot2 addi x7,x0,1 -> issue order 0,2,1; slot1
//     issues no earlier than LAT cycles after slot0 handshake.
//  T4 WAW/WAR: slot0 add x4,x8,x9; slot1 addi x8,x0,3 (WAR); slot2 addi x4,x0,1 (WAW) -> order 0,1,2.
//  T5 backpressure: issue_ready=0 for 5 cycles while issue_valid=1 -> issue_instr/issue_slot stable,
//     occupancy unchanged, no scoreboard update.
//  T6 reset mid-DRAIN with occupancy=7, pending x5 -> all outputs at reset values next cycle; new
//     stream reading x5 issues without stall.

Source files
------------

// File: rtl/esm_issue_scheduler.sv
// Buffered out-of-order issue controller: fills BS slots, then issues the oldest hazard-free slot each cycle.
// Define ESM_SCHED_STATS_EN to add the stat_issued/stat_stalls counters.
module esm_issue_scheduler #(
  parameter int IW     = 32,
  parameter int BS     = 16,
  parameter int REGNUM = 32,
  parameter int LAT    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [IW-1:0]         in_instr,
  input  logic                  in_regwrite,
  input  logic                  in_alusrc,
  output logic                  in_ready,
  output logic                  issue_valid,
  output logic [IW-1:0]         issue_instr,
  output logic [$clog2(BS)-1:0] issue_slot,
  input  logic                  issue_ready,
  output logic [$clog2(BS):0]   occupancy,
`ifdef ESM_SCHED_STATS_EN
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_stalls,
`endif
  output logic                  busy
);
  localparam int SW = $clog2(BS);
  localparam int RW = $clog2(REGNUM);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  state_t state, state_nxt;

  logic [IW-1:0]     slot_instr [BS];
  logic [RW-1:0]     slot_rs1   [BS];
  logic [RW-1:0]     slot_rs2   [BS];
  logic [RW-1:0]     slot_rd    [BS];
  logic [BS-1:0]     slot_vld, slot_use1, slot_use2, slot_wr;
  logic [BS-1:0]     slot_rdy, cand;
  logic [REGNUM-1:0] pending, pending_nxt;
  logic [LAT-1:0]    pipe_vld;
  logic [RW-1:0]     pipe_tag [LAT];
  logic              accept, fill_we, is_term, hs, sel_found;
  logic [SW-1:0]     sel_idx;
  logic [RW-1:0]     in_rs1, in_rs2, in_rd;

  assign in_rs1   = in_instr[15 +: RW];
  assign in_rs2   = in_instr[20 +: RW];
  assign in_rd    = in_instr[7 +: RW];
  assign is_term  = (in_instr == '0);
  assign in_ready = (state != DRAIN) && (occupancy < (SW+1)'(BS));
  assign accept   = in_valid && in_ready;
  assign fill_we  = accept && !is_term;
  assign hs       = issue_valid && issue_ready;
  assign busy     = (state != IDLE) || (|pending);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fill_we) state_nxt = FILL;
      FILL:    if (accept && (is_term || occupancy == (SW+1)'(BS-1))) state_nxt = DRAIN;
      DRAIN:   if (occupancy == '0 && !issue_valid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lower slot index is older; only older valid slots can block a younger one.
  always_comb begin
    slot_rdy = slot_vld;
    for (int i = 0; i < BS; i++) begin
      if ((slot_use1[i] && pending[slot_rs1[i]]) || (slot_use2[i] && pending[slot_rs2[i]]))
        slot_rdy[i] = 1'b0;
      for (int j = 0; j < BS; j++) begin
        if (j < i && slot_vld[j]) begin
          if (slot_wr[j] && ((slot_use1[i] && slot_rd[j] == slot_rs1[i]) ||
                             (slot_use2[i] && slot_rd[j] == slot_rs2[i])))
            slot_rdy[i] = 1'b0;
          if (slot_wr[i] && ((slot_wr[j]   && slot_rd[j]  == slot_rd[i]) ||
                             (slot_use1[j] && slot_rs1[j] == slot_rd[i]) ||
                             (slot_use2[j] && slot_rs2[j] == slot_rd[i])))
            slot_rdy[i] = 1'b0;
        end
      end
    end
  end

  // The handshaking slot still blocks its dependents this cycle but is not reselected.
  always_comb begin
    cand = (state == DRAIN && (!issue_valid || hs)) ? slot_rdy : '0;
    if (hs) cand[issue_slot] = 1'b0;
    sel_found = |cand;
    sel_idx   = '0;
    for (int i = BS-1; i >= 0; i--)
      if (cand[i]) sel_idx = SW'(i);
  end

  // Clear from the retiring tag first so a same-cycle set of that register wins.
  always_comb begin
    pending_nxt = pending;
    if (pipe_vld[LAT-1]) pending_nxt[pipe_tag[LAT-1]] = 1'b0;
    if (hs && slot_wr[issue_slot]) pending_nxt[slot_rd[issue_slot]] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      occupancy   <= '0;
      slot_vld    <= '0;
      slot_use1   <= '0;
      slot_use2   <= '0;
      slot_wr     <= '0;
      issue_valid <= 1'b0;
      issue_instr <= '0;
      issue_slot  <= '0;
      pending     <= '0;
      pipe_vld    <= '0;
      for (int i = 0; i < BS; i++) begin
        slot_instr[i] <= '0;
        slot_rs1[i]   <= '0;
        slot_rs2[i]   <= '0;
        slot_rd[i]    <= '0;
      end
      for (int k = 0; k < LAT; k++) pipe_tag[k] <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      for (int k = LAT-1; k > 0; k--) begin
        pipe_vld[k] <= pipe_vld[k-1];
        pipe_tag[k] <= pipe_tag[k-1];
      end
      pipe_vld[0] <= hs && slot_wr[issue_slot];
      pipe_tag[0] <= slot_rd[issue_slot];

      if (fill_we) begin
        occupancy                        <= occupancy + 1'b1;
        slot_vld[occupancy[SW-1:0]]      <= 1'b1;
        slot_instr[occupancy[SW-1:0]]    <= in_instr;
        slot_rs1[occupancy[SW-1:0]]      <= in_rs1;
        slot_rs2[occupancy[SW-1:0]]      <= in_rs2;
        slot_rd[occupancy[SW-1:0]]       <= in_rd;
        slot_use1[occupancy[SW-1:0]]     <= (in_rs1 != '0);
        slot_use2[occupancy[SW-1:0]]     <= !in_alusrc && (in_rs2 != '0);
        slot_wr[occupancy[SW-1:0]]       <= in_regwrite && (in_rd != '0);
      end else if (hs) begin
        occupancy            <= occupancy - 1'b1;
        slot_vld[issue_slot] <= 1'b0;
      end

      if (sel_found) begin
        issue_valid <= 1'b1;
        issue_instr <= slot_instr[sel_idx];
        issue_slot  <= sel_idx;
      end else if (hs) begin
        issue_valid <= 1'b0;
      end
    end
  end

`ifdef ESM_SCHED_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stalls <= '0;
    end else begin
      if (hs) stat_issued <= stat_issued + 32'd1;
      if (state == DRAIN && occupancy != '0 && !issue_valid) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_esm_issue_scheduler.sv
// Directed and randomized checks of esm_issue_scheduler against a cycle-level reference model.
module tb_esm_issue_scheduler;
  localparam int IW = 32, BS = 16, REGNUM = 32, LAT = 3, SW = $clog2(BS);

  logic          clk = 1'b0;
  logic          rst, in_valid, in_regwrite, in_alusrc, in_ready, issue_valid, issue_ready, busy;
  logic [IW-1:0] in_instr, issue_instr;
  logic [SW-1:0] issue_slot;
  logic [SW:0]   occupancy;
`ifdef ESM_SCHED_STATS_EN
  logic [31:0]   stat_issued, stat_stalls;
`endif

  esm_issue_scheduler #(.IW(IW), .BS(BS), .REGNUM(REGNUM), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr),
    .in_regwrite(in_regwrite), .in_alusrc(in_alusrc), .in_ready(in_ready),
    .issue_valid(issue_valid), .issue_instr(issue_instr), .issue_slot(issue_slot),
    .issue_ready(issue_ready), .occupancy(occupancy),
`ifdef ESM_SCHED_STATS_EN
    .stat_issued(stat_issued), .stat_stalls(stat_stalls),
`endif
    .busy(busy));

  always #5 clk = ~clk;

  // Reference model: buffer contents, state, scoreboard as in-flight (reg, exit edge) list.
  typedef struct { int r; int t; } tag_t;
  typedef struct { logic [31:0] w; bit rw; bit as; } ent_t;
  int          m_state, m_occ, m_islot, edge_no, n_vec, n_fail, term_edge, busy_fall_edge;
  bit          m_vld [BS];
  logic [31:0] m_ins [BS];
  bit          m_rw [BS];
  bit          m_as [BS];
  bit          m_pend [REGNUM];
  bit          m_iv, busy_q;
  logic [31:0] m_iins;
  tag_t        infl [$];
  ent_t        stim [$];
  int          hs_slot [$];
  int          hs_edge [$];

  function automatic logic [31:0] r_type(int rd, int rs1, int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
  endfunction
  function automatic logic [31:0] i_type(int rd, int rs1, int imm);
    return {12'(imm), 5'(rs1), 3'd0, 5'(rd), 7'b0010011};
  endfunction
  task automatic add_ent(input logic [31:0] w, input bit rw, input bit as);
    ent_t e;
    e.w = w; e.rw = rw; e.as = as;
    stim.push_back(e);
  endtask

  function automatic int src1(int i); return int'(m_ins[i][19:15]); endfunction
  function automatic int src2(int i); return m_as[i] ? 0 : int'(m_ins[i][24:20]); endfunction
  function automatic int dst(int i);  return m_rw[i] ? int'(m_ins[i][11:7]) : 0; endfunction

  function automatic bit m_ready(int i);
    int s1, s2, d;
    if (!m_vld[i]) return 0;
    s1 = src1(i); s2 = src2(i); d = dst(i);
    if ((s1 != 0 && m_pend[s1]) || (s2 != 0 && m_pend[s2])) return 0;
    for (int j = 0; j < i; j++) begin
      if (m_vld[j]) begin
        if (dst(j) != 0 && (dst(j) == s1 || dst(j) == s2)) return 0;
        if (d != 0 && (dst(j) == d || src1(j) == d || src2(j) == d)) return 0;
      end
    end
    return 1;
  endfunction

  function automatic bit m_inrdy(); return (m_state != 2) && (m_occ < BS); endfunction
  function automatic bit m_busy();
    bit b;
    b = (m_state != 0);
    for (int r = 0; r < REGNUM; r++) b |= m_pend[r];
    return b;
  endfunction

  task automatic model_reset();
    m_state = 0; m_occ = 0; m_iv = 0; m_iins = '0; m_islot = 0;
    infl.delete();
    for (int i = 0; i < BS; i++) begin m_vld[i] = 0; m_ins[i] = '0; m_rw[i] = 0; m_as[i] = 0; end
    for (int r = 0; r < REGNUM; r++) m_pend[r] = 0;
  endtask

  task automatic model_edge();
    bit hs, acc, nz;
    int sel, d;
    hs  = m_iv && issue_ready;
    acc = in_valid && m_inrdy();
    nz  = (in_instr != 0);
    sel = -1;
    d   = hs ? dst(m_islot) : 0;
    if (m_state == 2 && (!m_iv || hs))
      for (int i = 0; i < BS; i++)
        if (sel < 0 && !(hs && i == m_islot) && m_ready(i)) sel = i;
    case (m_state)
      0: if (acc && nz) m_state = 1;
      1: if (acc && (!nz || m_occ == BS-1)) m_state = 2;
      default: if (m_occ == 0 && !m_iv) m_state = 0;
    endcase
    if (acc && nz) begin
      m_vld[m_occ] = 1; m_ins[m_occ] = in_instr; m_rw[m_occ] = in_regwrite; m_as[m_occ] = in_alusrc;
      m_occ++;
    end
    if (hs) begin m_vld[m_islot] = 0; m_occ--; end
    for (int k = infl.size()-1; k >= 0; k--)
      if (infl[k].t == edge_no) begin m_pend[infl[k].r] = 0; infl.delete(k); end
    if (d != 0) begin
      tag_t t;
      t.r = d; t.t = edge_no + LAT;
      m_pend[d] = 1;
      infl.push_back(t);
    end
    if (sel >= 0) begin m_iv = 1; m_iins = m_ins[sel]; m_islot = sel; end
    else if (hs) m_iv = 0;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_issue_valid", issue_valid, 0);
    chk("rst_issue_instr", issue_instr, 0);
    chk("rst_issue_slot", issue_slot, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_busy", busy, 0);
  endtask

  task automatic step();
    bit hs_pre;
    int slot_pre;
    hs_pre   = issue_valid && issue_ready;
    slot_pre = int'(issue_slot);
    model_edge();
    @(posedge clk);
    #1;
    edge_no++;
    if (hs_pre) begin hs_slot.push_back(slot_pre); hs_edge.push_back(edge_no); end
    if (busy_q && !busy) busy_fall_edge = edge_no;
    busy_q = busy;
    chk("in_ready", in_ready, m_inrdy());
    chk("issue_valid", issue_valid, m_iv);
    chk("occupancy", occupancy, m_occ);
    chk("busy", busy, m_busy());
    if (m_iv) begin
      chk("issue_instr", issue_instr, m_iins);
      chk("issue_slot", issue_slot, m_islot);
    end
  endtask

  // ir_mode: 0 always ready, 1 random, 2 hold off for 5 cycles of issue_valid
  task automatic run_stream(input int ir_mode, input int stop_occ, input int inval_pct);
    int idx, nz, budget, hold;
    bit acc;
    idx = 0; nz = 0; budget = 0; hold = 0;
    hs_slot.delete(); hs_edge.delete(); term_edge = -1;
    forever begin
      if (idx < stim.size() && $urandom_range(99) < inval_pct) begin
        in_valid = 1; in_instr = stim[idx].w; in_regwrite = stim[idx].rw; in_alusrc = stim[idx].as;
      end else begin
        in_valid = 0; in_instr = '0; in_regwrite = 0; in_alusrc = 0;
      end
      case (ir_mode)
        0:       issue_ready = 1;
        1:       issue_ready = ($urandom_range(3) != 0);
        default: issue_ready = (hold >= 5);
      endcase
      acc = in_valid && m_inrdy();
      step();
      if (acc) begin
        if (stim[idx].w == 0) begin term_edge = edge_no; chk("term_occ", occupancy, nz); end
        else nz++;
        idx++;
      end
      if (ir_mode == 2 && hold < 5 && issue_valid) begin
        hold++;
        chk("bp_slot", issue_slot, 0);
        chk("bp_instr", issue_instr, stim[0].w);
        chk("bp_occ", occupancy, nz);
      end
      if (stop_occ >= 0 && m_state == 2 && m_occ == stop_occ) break;
      if (idx == stim.size() && m_state == 0 && !m_busy() && !busy) break;
      budget++;
      if (budget > 3000) begin chk("stream_done", (idx == stim.size()) && !busy, 1); break; end
    end
    in_valid = 0; in_instr = '0;
  endtask

  initial begin
    int len;
    n_vec = 0; n_fail = 0; edge_no = 0; busy_q = 0; busy_fall_edge = -1;
    rst = 1; in_valid = 0; in_instr = '0; in_regwrite = 0; in_alusrc = 0; issue_ready = 0;
    model_reset();
    #1 chk_reset();
    #2 rst = 0;

    // T1: sixteen independent ADDIs fill the buffer and issue in slot order
    stim.delete();
    for (int i = 0; i < 16; i++) add_ent(i_type(i+1, 0, 1), 1, 1);
    run_stream(0, -1, 100);
    chk("t1_count", hs_slot.size(), 16);
    for (int i = 0; i < 16; i++) chk("t1_order", (i < hs_slot.size()) ? hs_slot[i] : -1, i);
    if (hs_slot.size() == 16) begin
      chk("t1_b2b", hs_edge[15] - hs_edge[0], 15);
      chk("t1_busy_fall", busy_fall_edge - hs_edge[15], LAT);
    end

    // T2: terminator ends fill early and is never issued
    stim.delete();
    for (int i = 0; i < 3; i++) add_ent(i_type(20+i, 0, 7), 1, 1);
    add_ent(32'd0, 0, 0);
    run_stream(0, -1, 100);
    chk("t2_count", hs_slot.size(), 3);

    // T3: RAW on x5 pushes slot1 behind slot2
    stim.delete();
    add_ent(r_type(5, 1, 2), 1, 0);
    add_ent(r_type(6, 5, 3), 1, 0);
    add_ent(i_type(7, 0, 1), 1, 1);
    add_ent(32'd0, 0, 0);
    run_stream(0, -1, 100);
    chk("t3_count", hs_slot.size(), 3);
    if (hs_slot.size() == 3) begin
      chk("t3_order0", hs_slot[0], 0);
      chk("t3_order1", hs_slot[1], 2);
      chk("t3_order2", hs_slot[2], 1);
      chk("t3_gap", (hs_edge[2] - hs_edge[0]) >= LAT, 1);
    end

    // T4: WAR on x8 and WAW on x4 keep program order
    stim.delete();
    add_ent(r_type(4, 8, 9), 1, 0);
    add_ent(i_type(8, 0, 3), 1, 1);
    add_ent(i_type(4, 0, 1), 1, 1);
    add_ent(32'd0, 0, 0);
    run_stream(0, -1, 100);
    chk("t4_count", hs_slot.size(), 3);
    for (int i = 0; i < 3; i++) chk("t4_order", (i < hs_slot.size()) ? hs_slot[i] : -1, i);

    // T5: issue held stable under backpressure
    stim.delete();
    for (int i = 0; i < 4; i++) add_ent(i_type(12+i, 0, 2), 1, 1);
    add_ent(32'd0, 0, 0);
    run_stream(2, -1, 100);
    chk("t5_count", hs_slot.size(), 4);

    // T6: reset mid-drain with x5 pending, then a reader of x5 issues without stall
    stim.delete();
    add_ent(i_type(5, 0, 1), 1, 1);
    for (int i = 0; i < 7; i++) add_ent(i_type(10+i, 0, 1), 1, 1);
    add_ent(32'd0, 0, 0);
    run_stream(0, 7, 100);
    chk("t6_occ", occupancy, 7);
    #1 rst = 1;
    #1 chk_reset();
    model_reset();
    busy_q = 0;
    #1 rst = 0;
    stim.delete();
    add_ent(r_type(6, 5, 0), 1, 0);
    add_ent(32'd0, 0, 0);
    run_stream(0, -1, 100);
    chk("t6_count", hs_slot.size(), 1);
    if (hs_slot.size() == 1) chk("t6_nostall", hs_edge[0] - term_edge, 2);

    // Random streams over a small register set to provoke hazards and stalls
    for (int s = 0; s < 40; s++) begin
      stim.delete();
      len = $urandom_range(16, 1);
      if ($urandom_range(3) == 0) add_ent(32'd0, 0, 0);
      for (int i = 0; i < len; i++) begin
        bit as;
        as = $urandom_range(1);
        add_ent(as ? i_type($urandom_range(7), $urandom_range(7), $urandom_range(4095))
                   : r_type($urandom_range(7), $urandom_range(7), $urandom_range(7)),
                $urandom_range(1), as);
      end
      if (len < 16) add_ent(32'd0, 0, 0);
      run_stream(1, -1, 80);
      chk("rnd_count", hs_slot.size(), len);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
